// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: RAM word/handshake plus the memory arbiter FSM and grant encodings.
package cpu_types_pkg;

   typedef logic [31:0] word_t;

   typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;

   typedef enum logic [1:0] {IDLE, DSERV, ISERV, RESP} arb_state_t;

   typedef enum logic {GNT_I, GNT_D} grant_t;

endpackage

// File: rtl/memory_arbiter.sv
// Single RAM port shared between instruction fetch and data access, data first.
// Define ARB_FAIR_EN to let a waiting fetch through after FAIR_LIMIT back-to-back data grants.
module memory_arbiter
   import cpu_types_pkg::*;
#(
   parameter int WORD_W     = 32,
   parameter int TIMEOUT    = 15,
   parameter int FAIR_LIMIT = 4
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              iREN,
   input  logic [WORD_W-1:0] iaddr,
   output logic [WORD_W-1:0] iload,
   output logic              ihit,
   input  logic              dREN,
   input  logic              dWEN,
   input  logic [WORD_W-1:0] daddr,
   input  logic [WORD_W-1:0] dstore,
   output logic [WORD_W-1:0] dload,
   output logic              dhit,
   output logic              ramREN,
   output logic              ramWEN,
   output logic [WORD_W-1:0] ramaddr,
   output logic [WORD_W-1:0] ramstore,
   input  logic [WORD_W-1:0] ramload,
   input  ramstate_t         ramstate,
   output logic              memerr
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);

   arb_state_t       state, state_n;
   grant_t           gnt, gnt_n;
   logic [CNT_W-1:0] svc_cnt;
   logic             in_serv, dreq, req_live, fair_take, latch, abort_err;

`ifdef ARB_FAIR_EN
   localparam int FAIR_W = $clog2(FAIR_LIMIT + 1);
   logic [FAIR_W-1:0] fair_cnt;
`endif

   always_comb begin
      dreq      = dREN | dWEN;
      in_serv   = (state == DSERV) || (state == ISERV);
      req_live  = (gnt == GNT_D) ? dreq : iREN;
`ifdef ARB_FAIR_EN
      fair_take = iREN && (fair_cnt == FAIR_W'(FAIR_LIMIT));
`else
      fair_take = 1'b0;
`endif
      state_n   = state;
      gnt_n     = gnt;
      latch     = 1'b0;
      abort_err = 1'b0;
      case (state)
         IDLE: begin
            if (dreq && !fair_take) begin
               gnt_n   = GNT_D;
               state_n = DSERV;
            end else if (iREN) begin
               gnt_n   = GNT_I;
               state_n = ISERV;
            end
         end
         DSERV, ISERV: begin
            // Withdrawal beats a completing RAM cycle: the requester no longer wants the word.
            if (!req_live) begin
               state_n = IDLE;
            end else if (ramstate == ACCESS) begin
               state_n = RESP;
               latch   = 1'b1;
            end else if (ramstate == ERROR || svc_cnt == CNT_W'(TIMEOUT - 1)) begin
               state_n   = IDLE;
               abort_err = 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase

      ramREN   = in_serv && ((gnt == GNT_D) ? (dREN && !dWEN) : iREN);
      ramWEN   = in_serv && (gnt == GNT_D) && dWEN;
      ramaddr  = in_serv ? ((gnt == GNT_D) ? daddr : iaddr) : '0;
      ramstore = ramWEN ? dstore : '0;
      ihit     = (state == RESP) && (gnt == GNT_I);
      dhit     = (state == RESP) && (gnt == GNT_D);
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state   <= IDLE;
         gnt     <= GNT_I;
         svc_cnt <= '0;
         iload   <= '0;
         dload   <= '0;
         memerr  <= 1'b0;
`ifdef ARB_FAIR_EN
         fair_cnt <= '0;
`endif
      end else begin
         state   <= state_n;
         gnt     <= gnt_n;
         // Service always starts from IDLE, so clearing outside service restarts the count on entry.
         svc_cnt <= in_serv ? svc_cnt + CNT_W'(1) : '0;
         if (latch && gnt == GNT_I)           iload  <= ramload;
         if (latch && gnt == GNT_D && !dWEN)  dload  <= ramload;
         if (abort_err)                       memerr <= 1'b1;
`ifdef ARB_FAIR_EN
         if (!iREN || (state == IDLE && state_n == ISERV))
            fair_cnt <= '0;
         else if (state == IDLE && state_n == DSERV)
            fair_cnt <= fair_cnt + FAIR_W'(1);
`endif
      end
   end

endmodule

// File: tb/tb_memory_arbiter.sv
// Randomized and directed checks of memory_arbiter against a transaction-level model of grants, latency and errors.
module tb_memory_arbiter;
   import cpu_types_pkg::*;

   localparam int TO = 15;
   localparam int FL = 4;

   logic      CLK = 1'b0;
   logic      RST;
   logic      iREN, dREN, dWEN;
   word_t     iaddr, daddr, dstore, ramload;
   word_t     iload, dload, ramaddr, ramstore;
   logic      ihit, dhit, ramREN, ramWEN, memerr;
   ramstate_t ramstate;

   int    checks = 0;
   int    errors = 0;
   word_t exp_iload, exp_dload;
   bit    exp_err;
   int    streak;

   memory_arbiter #(.WORD_W(32), .TIMEOUT(TO), .FAIR_LIMIT(FL)) dut (
      .CLK(CLK), .RST(RST),
      .iREN(iREN), .iaddr(iaddr), .iload(iload), .ihit(ihit),
      .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dload(dload), .dhit(dhit),
      .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
      .ramload(ramload), .ramstate(ramstate), .memerr(memerr)
   );

   always #5 CLK = ~CLK;

   initial begin
      #500000;
      $display("FAIL watchdog act=timeout exp=finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%h exp=%h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic do_reset();
      RST = 1'b1;
      iREN = 1'b1; dREN = 1'b1; dWEN = 1'b0;
      iaddr = $urandom; daddr = $urandom; dstore = $urandom;
      ramstate = ACCESS; ramload = $urandom;
      step();
      step();
      chk("rst.ren",  ramREN,   0);
      chk("rst.wen",  ramWEN,   0);
      chk("rst.addr", ramaddr,  0);
      chk("rst.st",   ramstore, 0);
      chk("rst.hit",  {ihit, dhit}, 0);
      chk("rst.ild",  iload,    0);
      chk("rst.dld",  dload,    0);
      chk("rst.err",  memerr,   0);
      iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0; ramstate = FREE;
      RST = 1'b0;
      exp_iload = '0; exp_dload = '0; exp_err = 1'b0; streak = 0;
      step();
   endtask

   // Reference arbitration: data first, unless the fairness cap hands the slot to a waiting fetch.
   function automatic bit pick_d();
      bit d;
      d = dREN || dWEN;
`ifdef ARB_FAIR_EN
      if (iREN && streak == FL) d = 1'b0;
`endif
      if (!iREN)   streak = 0;
      else if (d)  streak++;
      else         streak = 0;
      return d;
   endfunction

   // Called in the IDLE cycle where the requests are visible; returns in the hit cycle or the post-abort cycle.
   task automatic serve(input string tag, input bit is_d, input int busy, input bit err, input word_t ld);
      bit    wr, tmo;
      int    svc;
      word_t a, s;
      wr  = is_d && dWEN;
      tmo = !err && busy >= TO;
      svc = tmo ? TO : busy + 1;
      a   = is_d ? daddr : iaddr;
      s   = wr ? dstore : '0;
      step();
      for (int c = 1; c <= svc; c++) begin
         chk({tag, ".ren"},  ramREN,   !wr);
         chk({tag, ".wen"},  ramWEN,   wr);
         chk({tag, ".addr"}, ramaddr,  a);
         chk({tag, ".st"},   ramstore, s);
         chk({tag, ".busyhit"}, {ihit, dhit}, 0);
         chk({tag, ".err"},  memerr,   exp_err);
         ramstate = (c <= busy) ? BUSY : (err ? ERROR : ACCESS);
         ramload  = (c == svc) ? ld : $urandom;
         step();
      end
      ramstate = FREE;
      if (err || tmo) begin
         exp_err = 1'b1;
         chk({tag, ".abhit"}, {ihit, dhit}, 0);
      end else begin
         if (is_d && !wr) exp_dload = ld;
         if (!is_d)       exp_iload = ld;
         chk({tag, ".ihit"}, ihit, !is_d);
         chk({tag, ".dhit"}, dhit, is_d);
      end
      chk({tag, ".ren2"}, {ramREN, ramWEN}, 0);
      chk({tag, ".ild"},  iload,  exp_iload);
      chk({tag, ".dld"},  dload,  exp_dload);
      chk({tag, ".merr"}, memerr, exp_err);
   endtask

   initial begin
      bit d;
      int n_i;
      do_reset();

      // zero-wait fetch
      iREN = 1'b1; iaddr = 32'h40;
      serve("zw", pick_d(), 0, 0, 32'h2402000A);
      iREN = 1'b0; step();

      // collision: data with 2 busy cycles, then the pending fetch
      iREN = 1'b1; dREN = 1'b1; daddr = 32'h100; iaddr = 32'h44;
      d = pick_d(); chk("col.win", d, 1);
      serve("col.d", d, 2, 0, 32'h11112222);
      dREN = 1'b0; step();
      serve("col.i", pick_d(), 0, 0, 32'h33334444);
      iREN = 1'b0; step();

      // write: dload holds previous read value
      dREN = 1'b1; dWEN = 1'b1; daddr = 32'h200; dstore = 32'hDEADBEEF;
      serve("wr", pick_d(), 1, 0, 32'h55556666);
      dREN = 1'b0; dWEN = 1'b0; step();

      // withdrawal mid-service: no hit, no latch, then immediate new access
      dREN = 1'b1; daddr = 32'h300;
      step(); ramstate = BUSY;
      step(); dREN = 1'b0; ramstate = ACCESS; ramload = 32'hBAD0BAD0;
      step(); ramstate = FREE;
      chk("wd.hit", {ihit, dhit}, 0);
      chk("wd.dld", dload, exp_dload);
      chk("wd.err", memerr, 0);
      dREN = 1'b1; daddr = 32'h304;
      serve("wd.re", pick_d(), 0, 0, 32'h77778888);
      dREN = 1'b0; step();

      // random traffic
      for (int k = 0; k < 40; k++) begin
         iREN = $urandom_range(0, 1); dREN = $urandom_range(0, 1); dWEN = $urandom_range(0, 1);
         if (!iREN && !dREN && !dWEN) iREN = 1'b1;
         iaddr = $urandom; daddr = $urandom; dstore = $urandom;
         while (iREN || dREN || dWEN) begin
            d = pick_d();
            serve("rnd", d, $urandom_range(0, 4), 0, $urandom);
            if (d) begin dREN = 1'b0; dWEN = 1'b0; end
            else iREN = 1'b0;
            step();
         end
         if ($urandom_range(0, 1) == 1) step();
      end

      // timeout: sticky memerr across a later good access, cleared by reset
      dREN = 1'b1; daddr = 32'h400;
      serve("tmo", pick_d(), TO + 3, 0, $urandom);
      dREN = 1'b0; step();
      chk("tmo.idlehit", {ihit, dhit}, 0);
      iREN = 1'b1; iaddr = 32'h48;
      serve("tmo.after", pick_d(), 0, 0, $urandom);
      iREN = 1'b0; step();
      do_reset();

      // RAM error aborts
      dREN = 1'b1; dWEN = 1'b1; daddr = 32'h500; dstore = $urandom;
      serve("rerr", pick_d(), 1, 1, $urandom);
      dREN = 1'b0; dWEN = 1'b0; step();
      do_reset();

      // reset during data service
      dREN = 1'b1; daddr = 32'h600; ramstate = BUSY;
      step();
      chk("mid.ren", ramREN, 1);
      #2 RST = 1'b1;
      #1;
      chk("mid.ren0", {ramREN, ramWEN}, 0);
      chk("mid.hit",  {ihit, dhit}, 0);
      dREN = 1'b0; ramstate = FREE;
      step(); RST = 1'b0; streak = 0; step();
      chk("mid.idle", {ihit, dhit, ramREN}, 0);
      dREN = 1'b1; daddr = 32'h604;
      serve("mid.re", pick_d(), 0, 0, $urandom);
      dREN = 1'b0; step();

      // continuous dREN and iREN: fetch only through the fairness cap
      do_reset();
      iREN = 1'b1; dREN = 1'b1; iaddr = 32'h80; daddr = 32'h700;
      n_i = 0;
      for (int g = 0; g < 6; g++) begin
         d = pick_d();
         if (!d) n_i++;
         serve("fair", d, 0, 0, $urandom);
         if (!d) iREN = 1'b0;
         step();
      end
`ifdef ARB_FAIR_EN
      chk("fair.fetch", n_i, 1);
`else
      chk("fair.fetch", n_i, 0);
`endif
      dREN = 1'b0; iREN = 1'b0; step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
